// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants and types for the SRAM-like request arbiter: source IDs,
// FSM state encoding, access sizes and the muxed memory command bundle.
package sram_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOCK_INST = 2'd1;
  localparam logic [1:0] LOCK_DATA = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int unsigned STREAK_W = 4;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic logic [1:0] lock_state(input logic src);
    return (src == SRC_DATA) ? LOCK_DATA : LOCK_INST;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_src_fifo.sv
// One-bit-wide FIFO recording the source of each accepted request so in-order
// responses can be routed back. The caller never pushes when full or pops when empty.
module sram_req_arbiter_src_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic src_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DEPTH-1:0] slot_q;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;

  always_comb begin
    wptr_d  = push_i ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop_i  ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) slot_q[wptr_q] <= src_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = slot_q[rptr_q];

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data requesters,
// with data priority, bounded instruction starvation and in-order response routing.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING     = 4,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_unexp_rsp
);

  logic [1:0]          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                err_q, err_d;

  logic     fifo_full, fifo_empty, fifo_head;
  logic     gnt_vld, gnt_src, accept, pop;
  mem_cmd_t inst_cmd, data_cmd, mem_cmd;

  // A presented-but-unaccepted request owns the port until the memory takes it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_INST;
    case (state_q)
      LOCK_INST: begin
        gnt_vld = 1'b1;
        gnt_src = SRC_INST;
      end
      LOCK_DATA: begin
        gnt_vld = 1'b1;
        gnt_src = SRC_DATA;
      end
      default: begin
        if (!fifo_full) begin
          if (data_req && (!inst_req || (32'(streak_q) < MAX_DATA_STREAK))) begin
            gnt_vld = 1'b1;
            gnt_src = SRC_DATA;
          end else if (inst_req) begin
            gnt_vld = 1'b1;
            gnt_src = SRC_INST;
          end
        end
      end
    endcase
    if (reset) gnt_vld = 1'b0;
  end

  assign accept = gnt_vld && mem_addr_ok;
  assign pop    = !reset && mem_data_ok && !fifo_empty;

  assign inst_cmd = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
  assign data_cmd = {data_wr, data_size, data_addr, data_wstrb, data_wdata};
  assign mem_cmd  = !gnt_vld ? '0 : (gnt_src == SRC_DATA) ? data_cmd : inst_cmd;

  assign mem_req = gnt_vld;
  assign {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} = mem_cmd;

  assign inst_addr_ok = accept && (gnt_src == SRC_INST);
  assign data_addr_ok = accept && (gnt_src == SRC_DATA);
  assign inst_data_ok = pop && (fifo_head == SRC_INST);
  assign data_data_ok = pop && (fifo_head == SRC_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  always_comb begin
    state_d = IDLE;
    if (gnt_vld && !mem_addr_ok) state_d = lock_state(gnt_src);

    streak_d = streak_q;
    if (!inst_req || inst_addr_ok) begin
      streak_d = '0;
    end else if (data_addr_ok && (streak_q != '1)) begin
      streak_d = streak_q + STREAK_W'(1);
    end

    err_d = err_q | (mem_data_ok && fifo_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  assign err_unexp_rsp = err_q;

  sram_req_arbiter_src_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_src_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (accept),
    .src_i   (gnt_src),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed and randomized bench for sram_req_arbiter against a queue-based
// reference model of grant, lock, streak and response-routing rules.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam int unsigned OUTSTANDING     = 4;
  localparam int unsigned MAX_DATA_STREAK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_unexp_rsp;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .OUTSTANDING     (OUTSTANDING),
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inst_req      (inst_req),
    .inst_wr       (inst_wr),
    .inst_size     (inst_size),
    .inst_addr     (inst_addr),
    .inst_wstrb    (inst_wstrb),
    .inst_wdata    (inst_wdata),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wstrb    (data_wstrb),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .mem_req       (mem_req),
    .mem_wr        (mem_wr),
    .mem_size      (mem_size),
    .mem_addr      (mem_addr),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_addr_ok   (mem_addr_ok),
    .mem_data_ok   (mem_data_ok),
    .mem_rdata     (mem_rdata),
    .err_unexp_rsp (err_unexp_rsp)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: outstanding sources in order, pending-port owner, streak, sticky error.
  int srcq[$];
  int lock_src = -1;
  int streak_m = 0;
  bit err_m    = 1'b0;
  bit acc_i, acc_d, obs_iaok, obs_daok;

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (reset) return -1;
    if (lock_src >= 0) return lock_src;
    if (srcq.size() >= int'(OUTSTANDING)) return -1;
    if (data_req && (!inst_req || streak_m < int'(MAX_DATA_STREAK))) return 1;
    if (inst_req) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    srcq.delete();
    lock_src = -1;
    streak_m = 0;
    err_m    = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic cycle();
    int g, head;
    logic [70:0] ecmd;
    bit pop;
    #1;
    g    = exp_grant();
    ecmd = (g == 0) ? {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata} :
           (g == 1) ? {data_wr, data_size, data_addr, data_wstrb, data_wdata} : '0;
    pop  = !reset && mem_data_ok && (srcq.size() > 0);
    head = pop ? srcq[0] : -1;
    obs_iaok = inst_addr_ok;
    obs_daok = data_addr_ok;
    chk("mem_req", 71'(mem_req), 71'(g >= 0));
    chk("mem_cmd", {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}, ecmd);
    chk("inst_addr_ok", 71'(inst_addr_ok), 71'(g == 0 && mem_addr_ok));
    chk("data_addr_ok", 71'(data_addr_ok), 71'(g == 1 && mem_addr_ok));
    chk("inst_data_ok", 71'(inst_data_ok), 71'(head == 0));
    chk("data_data_ok", 71'(data_data_ok), 71'(head == 1));
    chk("inst_rdata", 71'(inst_rdata), 71'((head == 0) ? mem_rdata : 32'h0));
    chk("data_rdata", 71'(data_rdata), 71'((head == 1) ? mem_rdata : 32'h0));
    chk("err_unexp_rsp", 71'(err_unexp_rsp), 71'(err_m));
    @(posedge clk);
    acc_i = (g == 0) && mem_addr_ok;
    acc_d = (g == 1) && mem_addr_ok;
    if (reset) begin
      model_reset();
    end else begin
      if (!inst_req || acc_i) streak_m = 0;
      else if (acc_d && streak_m < 15) streak_m++;
      lock_src = (g >= 0 && !mem_addr_ok) ? g : -1;
      if (acc_i) srcq.push_back(0);
      if (acc_d) srcq.push_back(1);
      if (mem_data_ok) begin
        if (pop) void'(srcq.pop_front());
        else err_m = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic new_inst(input logic [31:0] a);
    inst_req   = 1'b1;
    inst_wr    = 1'b0;
    inst_size  = SIZE_WORD;
    inst_addr  = a;
    inst_wstrb = 4'hF;
    inst_wdata = 32'h0;
  endtask

  task automatic new_data(input logic [31:0] a, input logic wr);
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = 2'($urandom_range(0, 2));
    data_addr  = a;
    data_wstrb = wr ? 4'hF : 4'($urandom);
    data_wdata = $urandom;
  endtask

  task automatic retire();
    if (acc_i) inst_req = 1'b0;
    if (acc_d) data_req = 1'b0;
  endtask

  task automatic drain();
    int k;
    mem_addr_ok = 1'b1;
    for (k = 0; k < 60 && (inst_req || data_req || srcq.size() > 0 || lock_src >= 0); k++) begin
      mem_data_ok = (srcq.size() > 0);
      mem_rdata   = $urandom;
      cycle();
      retire();
    end
    chk("drain_in_budget", 71'(k < 60), 71'(1));
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  initial begin
    int dacc, obs_dacc, first_inst;
    reset = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = '0; inst_addr = '0; inst_wstrb = '0;
    inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wstrb = '0;
    data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    // Outputs stay quiet under reset even with live requests and memory strobes.
    new_inst(32'h1C00_0000);
    new_data(32'h1C01_0000, 1'b1);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    cycle();
    reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    cycle();

    // Single instruction fetch, response two cycles later.
    new_inst(32'h1C00_0000);
    mem_addr_ok = 1'b1;
    cycle();
    retire();
    mem_addr_ok = 1'b0;
    cycle();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0280_0C0C;
    #1;
    chk("t1_inst_rdata", 71'(inst_rdata), 71'(32'h0280_0C0C));
    chk("t1_data_data_ok", 71'(data_data_ok), 71'(0));
    cycle();
    mem_data_ok = 1'b0;

    // Simultaneous requests: data wins, inst follows, responses route in order.
    new_inst(32'h1C00_0100);
    new_data(32'h1C01_0000, 1'b1);
    mem_addr_ok = 1'b1;
    #1;
    chk("t2_data_first", 71'(data_addr_ok), 71'(1));
    cycle();
    retire();
    cycle();
    retire();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hAAAA_5555;
    #1;
    chk("t2_rsp_data", 71'(data_data_ok), 71'(1));
    cycle();
    mem_rdata = 32'h1234_5678;
    #1;
    chk("t2_rsp_inst", 71'(inst_data_ok), 71'(1));
    cycle();
    mem_data_ok = 1'b0;

    // Data streak bound with a continuously pending instruction request.
    dacc = 0; obs_dacc = 0; first_inst = -1;
    mem_addr_ok = 1'b1;
    for (int k = 0; k < 40 && dacc < 10; k++) begin
      if (!data_req) new_data(32'h1C02_0000 + 32'(k * 4), 1'b0);
      if (!inst_req) new_inst(32'h1C00_1000 + 32'(k * 4));
      mem_data_ok = (srcq.size() > 0);
      mem_rdata   = $urandom;
      cycle();
      if (obs_iaok && first_inst < 0) first_inst = obs_dacc;
      if (obs_daok) obs_dacc++;
      if (acc_d) dacc++;
      retire();
    end
    chk("t3_data_before_inst", 71'(first_inst), 71'(MAX_DATA_STREAK));
    drain();

    // Stalled data request keeps the port while inst arrives.
    new_data(32'h1C03_0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) new_inst(32'h1C00_0200);
      #1;
      chk("t4_addr_locked", 71'(mem_addr), 71'(32'h1C03_0000));
      chk("t4_no_inst_ok", 71'(inst_addr_ok), 71'(0));
      cycle();
    end
    mem_addr_ok = 1'b1;
    cycle();
    retire();
    cycle();
    retire();
    drain();

    // Fill the source FIFO, then check the full bubble around a pop.
    mem_addr_ok = 1'b1;
    for (int k = 0; k < int'(OUTSTANDING); k++) begin
      new_data(32'h1C04_0000 + 32'(k * 4), 1'(k));
      cycle();
      retire();
    end
    new_inst(32'h1C00_0300);
    #1;
    chk("t5_full_blocks", 71'(mem_req), 71'(0));
    cycle();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hDEAD_0001;
    #1;
    chk("t5_pop_bubble", 71'(mem_req), 71'(0));
    cycle();
    mem_data_ok = 1'b0;
    #1;
    chk("t5_granted_after_pop", 71'(inst_addr_ok), 71'(1));
    cycle();
    retire();
    drain();

    // Randomized traffic under legal requester and in-order memory behaviour.
    for (int k = 0; k < 400; k++) begin
      if (!inst_req && $urandom_range(0, 2) == 0) new_inst($urandom & 32'hFFFF_FFFC);
      if (!data_req && $urandom_range(0, 1) == 0) new_data($urandom, 1'($urandom));
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = (srcq.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata   = $urandom;
      cycle();
      retire();
    end
    drain();

    // Unexpected response sets the sticky error; async reset clears everything at once.
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hBAD0_BAD0;
    cycle();
    mem_data_ok = 1'b0;
    #1;
    chk("t6_err_set", 71'(err_unexp_rsp), 71'(1));
    cycle();
    cycle();
    new_inst(32'h1C00_0400);
    new_data(32'h1C05_0000, 1'b0);
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_err_clr", 71'(err_unexp_rsp), 71'(0));
    chk("t6_async_mem_req", 71'(mem_req), 71'(0));
    chk("t6_async_addr", 71'(mem_addr), 71'(0));
    chk("t6_async_addr_ok", 71'({inst_addr_ok, data_addr_ok}), 71'(0));
    model_reset();
    cycle();
    reset = 1'b0;
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one like-SRAM memory port between the IF-stage instruction requester and the EXE/MEM-stage data requester.
- Sits between the pipeline core and the single memory/bus bridge.
- Tracks the source of every outstanding request so in-order responses return to the right requester.
- Data has priority over instruction requests; an anti-starvation counter bounds instruction wait.

Parameters:
- OUTSTANDING, 4, max accepted-but-unanswered requests (power of 2, >=2).
- MAX_DATA_STREAK, 4, consecutive data grants allowed while an inst request is pending.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  inst request valid; held until inst_addr_ok.
- inst_wr  in  1  write flag (always 0 from IF, passed through).
- inst_size  in  2  0=byte, 1=half, 2=word.
- inst_addr  in  32  request address.
- inst_wstrb  in  4  byte strobes.
- inst_wdata  in  32  write data.
- inst_addr_ok  out  1  inst request accepted this cycle.
- inst_data_ok  out  1  inst response valid.
- inst_rdata  out  32  inst response data.
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata: in, same widths and meaning for the data requester.
- data_addr_ok, data_data_ok, data_rdata: out, same widths and meaning for the data requester.
- mem_req  out  1  shared request valid.
- mem_wr  out  1  muxed write flag.
- mem_size  out  2  muxed size.
- mem_addr  out  32  muxed address.
- mem_wstrb  out  4  muxed byte strobes.
- mem_wdata  out  32  muxed write data.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory response valid (in order).
- mem_rdata  in  32  memory response data.
- err_unexp_rsp  out  1  sticky flag: mem_data_ok seen with no outstanding request.

Behaviour:
- Reset (async): state=IDLE, FIFO empty, count=0, streak=0, err_unexp_rsp=0. All handshake outputs are combinational and are 0 while reset is asserted.
- Grant source in IDLE, zero-cycle combinational:
  - FIFO full -> no grant, mem_req=0.
  - Else if data_req and (!inst_req or streak<MAX_DATA_STREAK) -> grant data.
  - Else if inst_req -> grant inst.
- Lock rule:
  - mem_req=1 and !mem_addr_ok -> go to LOCK(src). mem_* stays driven from src every cycle until mem_addr_ok.
  - No re-arbitration in LOCK, even if the other requester raises req.
  - LOCK -> IDLE on mem_addr_ok.
- Muxing: mem_wr/size/addr/wstrb/wdata come from the granted source. With no grant, mem_req=0 and the other mem_* outputs are 0.
- Accept: x_addr_ok = mem_addr_ok and granted==x. Only one of inst_addr_ok/data_addr_ok is high in any cycle.
- Accept pushes src (0=inst, 1=data) into the OUTSTANDING-deep source FIFO; count increments.
- Streak counter (4 bits, saturating):
  - data accepted while inst_req=1 -> +1.
  - inst accepted, or inst_req=0 -> reset to 0.
- Response:
  - mem_data_ok with FIFO non-empty -> pop head, pulse x_data_ok for head src, x_rdata=mem_rdata.
  - The other requester's rdata=0, data_ok=0.
  - Latency is zero cycles from mem_data_ok.
- Unexpected response: mem_data_ok with FIFO empty -> no data_ok to either side, err_unexp_rsp<=1 (cleared only by reset).
- Simultaneous push and pop: both happen and count is unchanged.
  - At full, a grant is blocked by the full check even if a pop happens the same cycle. This is a deliberate one-cycle bubble.
- Wrap-around: read/write pointers are log2(OUTSTANDING) bits and wrap naturally. count is log2(OUTSTANDING)+1 bits.
- Reset mid-transaction: FIFO and LOCK are cleared. The memory side must be reset in the same cycle; late responses after reset raise err_unexp_rsp.

Decomposition:
- Shared package: SRC_INST=1'b0, SRC_DATA=1'b1, state encoding (IDLE, LOCK_INST, LOCK_DATA), SIZE_BYTE/HALF/WORD constants.
- One sub-module: src_fifo (1-bit wide, OUTSTANDING deep, push/pop/full/empty/head).

Test Plan:
- inst_req only, addr=0x1C000000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with rdata=0x02800C0C -> inst_addr_ok=1 in cycle 0, inst_data_ok=1 with rdata 0x02800C0C, data_data_ok stays 0.
- inst_req and data_req together (data wr=1, addr=0x1C010000, wstrb=0xF) -> data granted first; inst granted next accepted cycle; responses route data then inst.
- data_req held high for 10 accepts with inst_req high -> inst granted exactly after the 4th data accept; streak returns to 0.
- mem_addr_ok held low 3 cycles with data granted, inst_req rising in cycle 1 -> mem_addr stays data_addr for all 3 cycles; no inst_addr_ok until after.
- 4 accepts with no response -> 5th request sees mem_req=0. One mem_data_ok pops, and the next cycle the request is granted.
- mem_data_ok with empty FIFO -> err_unexp_rsp=1 and stays 1. Assert reset -> err_unexp_rsp=0 and all outputs 0 immediately (async).
